// File: rtl/voter_pkg.sv
// voter_pkg: shared defaults and width helper for threshold_voter
package voter_pkg;
  localparam int N_DEF = 4;
  localparam int THRESH_DEF = 3;
  localparam int PERSIST_DEF = 4;
  localparam int CNT_W = 8;
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/threshold_voter_if.sv
// threshold_voter_if: sample/result bundle between a driver and the voter
interface threshold_voter_if import voter_pkg::*; #(parameter int N = N_DEF);
  localparam int W = cnt_width(N);
  logic in_valid;
  logic [N-1:0] in_bits;
  logic clear_faults;
  logic out_valid;
  logic x;
  logic [W-1:0] ones_count;
  logic no_quorum;
  logic [N-1:0] fault_mask;
  modport master(output in_valid, in_bits, clear_faults, input out_valid, x, ones_count, no_quorum, fault_mask);
  modport slave(input in_valid, in_bits, clear_faults, output out_valid, x, ones_count, no_quorum, fault_mask);
endinterface

// File: rtl/threshold_voter_cnt.sv
// vote_persist_cnt: per-channel disagreement counter with sticky fault flag
module vote_persist_cnt import voter_pkg::*; #(
  parameter int PERSIST = PERSIST_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic differ,
  input  logic clear,
  output logic [CNT_W-1:0] cnt,
  output logic fault
);
  localparam logic [CNT_W:0] LIM = PERSIST[CNT_W:0];
  logic [CNT_W:0] nxt;
  logic hit;
  assign nxt = {1'b0, cnt} + 1'b1;
  assign hit = differ && nxt == LIM;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      fault <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
      fault <= 1'b0;
    end else if (en && !fault) begin
      cnt <= (!differ || hit) ? '0 : (&cnt ? cnt : nxt[CNT_W-1:0]);
      fault <= hit;
    end
endmodule

// File: rtl/threshold_voter.sv
// threshold_voter: k-of-N voter over non-faulted channels with persistence-based fault masking
module threshold_voter import voter_pkg::*; #(
  parameter int N = N_DEF,
  parameter int THRESH = THRESH_DEF,
  parameter int PERSIST = PERSIST_DEF
) (
  input logic clk,
  input logic rst_n,
  threshold_voter_if.slave bus
);
  localparam int W = cnt_width(N);
  localparam logic [W-1:0] TH = W'(THRESH);
  logic [W-1:0] c, a;
  logic quorum, vote;
  logic [N-1:0] mask;
  logic [CNT_W-1:0] cnt [N];
  always_comb begin
    c = '0;
    a = '0;
    for (int i = 0; i < N; i++) begin
      a = a + W'(!mask[i]);
      c = c + W'(bus.in_bits[i] & !mask[i]);
    end
  end
  assign quorum = a >= TH;
  assign vote = c >= TH;
  assign bus.fault_mask = mask;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.x <= 1'b0;
      bus.ones_count <= '0;
      bus.no_quorum <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.ones_count <= c;
        bus.no_quorum <= !quorum;
        bus.x <= quorum ? vote : bus.x;
      end
    end
  // counters only move on quorum samples; the mask used here is the pre-edge one
  for (genvar i = 0; i < N; i++) begin : g_ch
    vote_persist_cnt #(.PERSIST(PERSIST)) u_cnt (
      .clk(clk),
      .rst_n(rst_n),
      .en(bus.in_valid && quorum),
      .differ(bus.in_bits[i] != vote),
      .clear(bus.clear_faults),
      .cnt(cnt[i]),
      .fault(mask[i])
    );
  end
endmodule

// File: tb/tb_threshold_voter.sv
// tb_threshold_voter: directed stimulus, reference model and per-cycle comparison
module tb_threshold_voter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  threshold_voter_if #(.N(4)) bus ();
  threshold_voter #(.N(4), .THRESH(3), .PERSIST(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  bit mov, mx, mnq;
  int mones;
  logic [3:0] mm;
  int mc [4];
  int m_act, m_ones;
  bit m_vote;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mov = 0; mx = 0; mnq = 0; mones = 0; mm = 4'b0;
      for (int i = 0; i < 4; i++) mc[i] = 0;
    end else begin
      m_act = $countones(~mm);
      m_ones = $countones(bus.in_bits & ~mm);
      m_vote = m_ones >= 3;
      mov = bus.in_valid;
      if (bus.in_valid) begin
        mones = m_ones;
        mnq = m_act < 3;
        if (m_act >= 3) mx = m_vote;
      end
      if (bus.clear_faults) begin
        mm = 4'b0;
        for (int i = 0; i < 4; i++) mc[i] = 0;
      end else if (bus.in_valid && m_act >= 3) begin
        for (int i = 0; i < 4; i++)
          if (!mm[i]) begin
            if (bus.in_bits[i] != m_vote) begin
              mc[i] = mc[i] + 1;
              if (mc[i] == 4) begin mm[i] = 1'b1; mc[i] = 0; end
              else if (mc[i] > 255) mc[i] = 255;
            end else mc[i] = 0;
          end
      end
    end
  always @(negedge clk)
    if (rst_n) begin
      chk("out_valid", bus.out_valid, mov);
      chk("x", bus.x, mx);
      chk("ones_count", bus.ones_count, mones);
      chk("no_quorum", bus.no_quorum, mnq);
      chk("fault_mask", bus.fault_mask, mm);
      for (int i = 0; i < 4; i++) chk($sformatf("cnt%0d", i), dut.cnt[i], mc[i]);
    end
  task automatic step(input bit v, input logic [3:0] b, input bit c);
    bus.in_valid = v;
    bus.in_bits = b;
    bus.clear_faults = c;
    @(negedge clk);
  endtask
  initial begin
    bus.in_valid = 0; bus.in_bits = 4'b0; bus.clear_faults = 0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst fault_mask", bus.fault_mask, 0);
    rst_n = 1'b1;
    // reset between edges with a sample pending
    step(1, 4'hF, 0);
    bus.in_valid = 1; bus.in_bits = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", bus.out_valid, 0);
    chk("async x", bus.x, 0);
    chk("async ones", bus.ones_count, 0);
    chk("async no_quorum", bus.no_quorum, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 4'hF, 0);
    chk("s1 out_valid", bus.out_valid, 1);
    chk("s1 x", bus.x, 1);
    chk("s1 ones", bus.ones_count, 4);
    step(0, 4'h0, 0);
    chk("s1 idle out_valid", bus.out_valid, 0);
    chk("s1 idle x hold", bus.x, 1);
    // sweep with clear on every sample so the mask stays empty
    for (int v = 0; v < 16; v++) begin
      step(1, 4'(v), 1);
      chk($sformatf("s2 x[%0d]", v), bus.x, (v == 7 || v == 11 || v == 13 || v == 14 || v == 15) ? 1 : 0);
      chk($sformatf("s2 valid[%0d]", v), bus.out_valid, 1);
    end
    for (int k = 0; k < 4; k++) step(1, 4'b0001, 0);
    chk("s3 mask", bus.fault_mask, 4'b0001);
    step(1, 4'b1110, 0);
    chk("s3 x", bus.x, 1);
    chk("s3 ones", bus.ones_count, 3);
    step(0, 4'h0, 1);
    for (int k = 0; k < 3; k++) step(1, 4'b0001, 0);
    step(1, 4'b0000, 0);
    for (int k = 0; k < 3; k++) step(1, 4'b0001, 0);
    chk("s4 mask", bus.fault_mask, 0);
    chk("s4 cnt0", dut.cnt[0], 3);
    step(0, 4'h0, 1);
    for (int k = 0; k < 4; k++) step(1, 4'b0011, 0);
    chk("s5 mask", bus.fault_mask, 4'b0011);
    step(1, 4'b1100, 0);
    chk("s5 no_quorum", bus.no_quorum, 1);
    chk("s5 x hold", bus.x, 0);
    chk("s5 ones", bus.ones_count, 2);
    chk("s5 cnt2", dut.cnt[2], 0);
    chk("s5 cnt3", dut.cnt[3], 0);
    step(1, 4'hF, 1);
    chk("s6 no_quorum", bus.no_quorum, 1);
    chk("s6 ones", bus.ones_count, 2);
    chk("s6 mask", bus.fault_mask, 0);
    chk("s6 cnt0", dut.cnt[0], 0);
    chk("s6 cnt1", dut.cnt[1], 0);
    step(1, 4'hF, 0);
    chk("s6 post x", bus.x, 1);
    chk("s6 post ones", bus.ones_count, 4);
    step(0, 4'h0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/threshold_voter.md
THRESHOLD_VOTER -- requirements
Module: threshold_voter

Interface
REQ-001 Parameter N, default 4: number of input channels, legal range 2..16.
REQ-002 Parameter THRESH, default 3: minimum ones among active channels for x=1, legal range 1..N.
REQ-003 Parameter PERSIST, default 4: consecutive disagreeing samples that fault a channel, legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_bits carries a sample this cycle.
REQ-007 in_bits  input  N  channel votes; bit i is channel i.
REQ-008 clear_faults  input  1  one-cycle request to clear all fault state.
REQ-009 out_valid  output  1  x, ones_count and no_quorum are updated this cycle.
REQ-010 x  output  1  registered voted result.
REQ-011 ones_count  output  clog2(N+1)  registered count of ones among active channels.
REQ-012 no_quorum  output  1  registered flag: active channels fewer than THRESH.
REQ-013 fault_mask  output  N  sticky per-channel fault flags; bit i set means channel i is excluded.

Function
REQ-014 A channel SHALL be active when its fault_mask bit is 0 at the sampling edge.
REQ-015 On in_valid=1, the block SHALL count ones over active channels (cnt) and active channels (act), both zero-extended to clog2(N+1) bits with no overflow.
REQ-016 The vote SHALL be 1 when act>=THRESH and cnt>=THRESH, 0 when act>=THRESH and cnt<THRESH, and no-quorum when act<THRESH.
REQ-017 Latency SHALL be exactly 1 cycle: out_valid pulses high for one cycle on the edge after in_valid=1, and is 0 otherwise.
REQ-018 With quorum, x SHALL take the vote and no_quorum SHALL be 0; without quorum, x SHALL hold its previous value and no_quorum SHALL be 1.
REQ-019 ones_count SHALL update on every valid sample, including no-quorum samples.
REQ-020 x, ones_count and no_quorum SHALL hold their values when in_valid=0.
REQ-021 Each channel SHALL have a disagreement counter, 8 bits wide and saturating at 255.
REQ-022 On a valid quorum sample, the counter of an active channel SHALL increment when its bit differs from the vote and SHALL clear to 0 when it agrees.
REQ-023 When an increment brings a counter to PERSIST, the channel's fault_mask bit SHALL set on that edge and its counter SHALL clear to 0.
REQ-024 Counters of masked channels SHALL stay 0.
REQ-025 On no-quorum samples and when in_valid=0, all counters SHALL hold.
REQ-026 fault_mask bits SHALL be sticky until clear_faults or reset.
REQ-027 clear_faults=1 SHALL clear all fault_mask bits and all counters on the next edge.
REQ-028 When clear_faults and in_valid are both 1, the sample SHALL be voted using the pre-clear mask, and the clear SHALL win over any counter or mask update.
REQ-029 Several channels reaching PERSIST on the same sample SHALL all be masked on that edge.

Reset
REQ-030 While rst_n=0, out_valid, x, ones_count, no_quorum, fault_mask and all counters SHALL be 0 immediately, regardless of clk.
REQ-031 Reset asserted mid-operation SHALL discard any in-flight sample; the first out_valid after release SHALL come 1 cycle after the first post-release in_valid.
REQ-032 Reset release SHALL take effect on a clk edge with no extra flush cycles.

Structure
REQ-033 A shared package voter_pkg SHALL hold the default N, THRESH and PERSIST values, the counter width constant (8), and a clog2-based width function.
REQ-034 The per-channel counter and fault flag SHALL be one sub-module, vote_persist_cnt, instantiated N times by generate.
REQ-035 The population count and compare logic SHALL be combinational in the top level, feeding a single output register stage.

Verification (N=4, THRESH=3, PERSIST=4)
REQ-036 Scenario 1: hold rst_n=0 mid-stream with in_bits=1111 and in_valid=1 -> all outputs 0 with no clock edge; release, send 1111 -> x=1 and ones_count=3'd4 one cycle later.
REQ-037 Scenario 2: exhaustive sweep of all 16 in_bits values with in_valid=1 -> x=1 exactly for 0111, 1011, 1101, 1110 and 1111; out_valid one cycle after each sample.
REQ-038 Scenario 3: in_bits=0001 for 4 consecutive valid cycles -> fault_mask=0001 after the 4th edge; then 1110 -> x=1 and ones_count=3.
REQ-039 Scenario 4: channel 0 disagrees 3 times, agrees once, then disagrees 3 times -> fault_mask stays 0000.
REQ-040 Scenario 5: mask channels 0 and 1, then send 1100 -> no_quorum=1, x holds its prior value, ones_count=2, and channels 2 and 3 counters unchanged.
REQ-041 Scenario 6: fault_mask=0011, then clear_faults=1 with in_valid=1 and in_bits=1111 -> that sample gives no_quorum=1 and ones_count=2; next edge gives fault_mask=0000 and all counters 0.
